// File: rtl/xrbase_alfred_irq_pkg.sv
// Shared types and defaults for the xrbase_alfred interrupt controller.
package xrbase_alfred_irq_pkg;

    localparam int unsigned DEF_NUM_IRQ = 33;
    localparam int unsigned DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2
    } irq_state_e;

endpackage : xrbase_alfred_irq_pkg

// File: rtl/xrbase_alfred_irq_prio_enc.sv
// Lowest-index-wins priority encoder, purely combinational.
module xrbase_alfred_irq_prio_enc #(
    parameter int unsigned N = 33,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    output logic         o_any_c,
    output logic [W-1:0] o_id_c
);

    // Scan from the top down so the lowest set index is the last to win.
    always_comb begin
        o_any_c = |i_req;
        o_id_c  = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id_c = W'(i);
            end
        end
    end

endmodule : xrbase_alfred_irq_prio_enc

// File: rtl/xrbase_alfred_irq_ctrl.sv
// Interrupt controller: pending latch, edge detect, fixed-priority claim FSM
// and a saturating counter of edges that were coalesced into a pending bit.
module xrbase_alfred_irq_ctrl
    import xrbase_alfred_irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ = DEF_NUM_IRQ,
    parameter int unsigned ID_W    = $clog2(NUM_IRQ),
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] cfg_edge,
    input  logic [NUM_IRQ-1:0] cfg_mask,
    output logic               irq_valid,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    output logic [NUM_IRQ-1:0] pending,
    output logic [CNT_W-1:0]   ovf_cnt,
    input  logic               ovf_clr
);

    irq_state_e         r_state;
    irq_state_e         w_state_nxt;
    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic               r_valid;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_id_nxt;
    logic [CNT_W-1:0]   r_ovf;

    logic [NUM_IRQ-1:0] w_edge;
    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_cand;
    logic               w_ack;
    logic               w_coal;
    logic               w_any;
    logic [ID_W-1:0]    w_win;

    assign w_edge = irq_in & ~r_prev;
    assign w_set  = (cfg_edge & w_edge) | (~cfg_edge & irq_in);
    assign w_ack  = (r_state == ST_PRESENT) && irq_ack;
    assign w_clr  = w_ack ? (NUM_IRQ'(1) << r_id) : '0;
    assign w_cand = r_pending & cfg_mask;
    // An edge that lands on a bit already pending (and not being acked) is lost.
    assign w_coal = |(cfg_edge & w_edge & r_pending & ~w_clr);

    xrbase_alfred_irq_prio_enc #(
        .N (NUM_IRQ),
        .W (ID_W)
    ) u_prio_enc (
        .i_req   (w_cand),
        .o_any_c (w_any),
        .o_id_c  (w_win)
    );

    // Edge history and pending register; a same-cycle set beats the ack clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_prev    <= irq_in;
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // Claim FSM next-state: ID is captured once in IDLE and frozen until ack.
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_PRESENT;
                    w_id_nxt    = w_win;
                end
            end
            ST_PRESENT: begin
                if (irq_ack) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Claim FSM state and registered presentation outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt == ST_PRESENT);
            r_id    <= w_id_nxt;
        end
    end

    // Coalesced-edge counter: clear beats increment, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= '0;
        end else if (ovf_clr) begin
            r_ovf <= '0;
        end else if (w_coal && !(&r_ovf)) begin
            r_ovf <= r_ovf + CNT_W'(1);
        end
    end

    assign irq_valid = r_valid;
    assign irq_id    = r_id;
    assign pending   = r_pending;
    assign ovf_cnt   = r_ovf;

endmodule : xrbase_alfred_irq_ctrl

// File: tb/tb_xrbase_alfred_irq_ctrl.sv
// Vector-table bench for the interrupt controller plus a small saturation
// sequence on a narrow-counter instance.
module tb_xrbase_alfred_irq_ctrl;

    localparam int unsigned N  = 33;
    localparam int unsigned IW = 6;
    localparam int unsigned CW = 16;
    localparam logic [N-1:0] MA  = 33'h1_FFFF_FFFF;
    localparam logic [N-1:0] M9  = 33'h1_FFFF_FDFF;
    localparam logic [N-1:0] EDG = 33'h1_FFFF_FFFB;

    logic          clk;
    logic          rst;
    logic [N-1:0]  irq_in;
    logic [N-1:0]  cfg_edge;
    logic [N-1:0]  cfg_mask;
    logic          irq_valid;
    logic [IW-1:0] irq_id;
    logic          irq_ack;
    logic [N-1:0]  pending;
    logic [CW-1:0] ovf_cnt;
    logic          ovf_clr;

    logic          b_rst;
    logic [7:0]    b_irq;
    logic [7:0]    b_edge;
    logic [7:0]    b_mask;
    logic          b_valid;
    logic [2:0]    b_id;
    logic          b_ack;
    logic [7:0]    b_pend;
    logic [1:0]    b_ovf;
    logic          b_clr;

    int checks;
    int failures;
    int row;

    typedef struct {
        logic         rst;
        logic [N-1:0] irq;
        logic [N-1:0] msk;
        logic         ack;
        logic         clr;
        logic         vld;
        logic [IW-1:0] id;
        logic [N-1:0] pnd;
        logic [CW-1:0] ovf;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    xrbase_alfred_irq_ctrl #(.NUM_IRQ(N), .ID_W(IW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .cfg_edge(cfg_edge),
        .cfg_mask(cfg_mask), .irq_valid(irq_valid), .irq_id(irq_id),
        .irq_ack(irq_ack), .pending(pending), .ovf_cnt(ovf_cnt),
        .ovf_clr(ovf_clr)
    );

    xrbase_alfred_irq_ctrl #(.NUM_IRQ(8), .ID_W(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(b_rst), .irq_in(b_irq), .cfg_edge(b_edge),
        .cfg_mask(b_mask), .irq_valid(b_valid), .irq_id(b_id),
        .irq_ack(b_ack), .pending(b_pend), .ovf_cnt(b_ovf),
        .ovf_clr(b_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [N-1:0] irq, input logic [N-1:0] msk,
                       input logic ack, input logic clr, input logic vld,
                       input int id, input logic [N-1:0] pnd, input int ovf);
        vec_t v;
        v.rst = r; v.irq = irq; v.msk = msk; v.ack = ack; v.clr = clr;
        v.vld = vld; v.id = IW'(id); v.pnd = pnd; v.ovf = CW'(ovf);
        vecs.push_back(v);
    endtask

    task automatic b_step(input logic [7:0] irq, input logic clr);
        @(negedge clk);
        b_irq = irq;
        b_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0; checks = 0; failures = 0; row = 0;
        rst = 1'b1; irq_in = '0; cfg_edge = EDG; cfg_mask = MA; irq_ack = 1'b0; ovf_clr = 1'b0;
        b_rst = 1'b1; b_irq = '0; b_edge = 8'hFF; b_mask = 8'hFF; b_ack = 1'b0; b_clr = 1'b0;

        // rst, irq, mask, ack, clr | valid, id, pending, ovf (after the edge)
        add(1, 0,         MA, 0, 0,  0, 0, 0,         0);   // 0 reset
        add(0, 33'h20,    MA, 0, 0,  0, 0, 33'h20,    0);   // 1 edge src5
        add(0, 0,         MA, 0, 0,  1, 5, 33'h20,    0);
        add(0, 0,         MA, 0, 0,  1, 5, 33'h20,    0);
        add(0, 0,         MA, 1, 0,  0, 5, 0,         0);   // 4 ack
        add(0, 0,         MA, 0, 0,  0, 0, 0,         0);
        add(0, 33'h88,    MA, 0, 0,  0, 0, 33'h88,    0);   // 6 src7+src3
        add(0, 0,         MA, 0, 0,  1, 3, 33'h88,    0);
        add(0, 33'h1,     MA, 0, 0,  1, 3, 33'h89,    0);   // 8 src0 during PRESENT
        add(0, 0,         MA, 0, 0,  1, 3, 33'h89,    0);
        add(0, 0,         MA, 1, 0,  0, 3, 33'h81,    0);
        add(0, 0,         MA, 0, 0,  0, 0, 33'h81,    0);
        add(0, 0,         MA, 0, 0,  1, 0, 33'h81,    0);
        add(0, 0,         MA, 1, 0,  0, 0, 33'h80,    0);
        add(0, 0,         MA, 0, 0,  0, 0, 33'h80,    0);
        add(0, 0,         MA, 0, 0,  1, 7, 33'h80,    0);
        add(0, 0,         MA, 1, 0,  0, 7, 0,         0);
        add(0, 0,         MA, 0, 0,  0, 0, 0,         0);
        add(0, 33'h4,     MA, 0, 0,  0, 0, 33'h4,     0);   // 18 level src2
        add(0, 33'h4,     MA, 0, 0,  1, 2, 33'h4,     0);
        add(0, 33'h4,     MA, 1, 0,  0, 2, 33'h4,     0);   // 20 ack, re-pends
        add(0, 33'h4,     MA, 0, 0,  0, 0, 33'h4,     0);
        add(0, 33'h4,     MA, 0, 0,  1, 2, 33'h4,     0);
        add(0, 0,         MA, 0, 0,  1, 2, 33'h4,     0);
        add(0, 0,         MA, 1, 0,  0, 2, 0,         0);
        add(0, 0,         MA, 0, 0,  0, 0, 0,         0);
        add(0, 33'h200,   M9, 0, 0,  0, 0, 33'h200,   0);   // 26 masked src9
        add(0, 0,         M9, 0, 0,  0, 0, 33'h200,   0);
        add(0, 0,         M9, 0, 0,  0, 0, 33'h200,   0);
        add(0, 0,         MA, 0, 0,  1, 9, 33'h200,   0);   // 29 unmask
        add(0, 0,         MA, 1, 0,  0, 9, 0,         0);
        add(0, 0,         MA, 0, 0,  0, 0, 0,         0);
        add(0, 33'h10,    MA, 0, 0,  0, 0, 33'h10,    0);   // 32 src4 edges
        add(0, 0,         MA, 0, 0,  1, 4, 33'h10,    0);
        add(0, 33'h10,    MA, 0, 0,  1, 4, 33'h10,    1);
        add(0, 0,         MA, 0, 0,  1, 4, 33'h10,    1);
        add(0, 33'h10,    MA, 0, 0,  1, 4, 33'h10,    2);
        add(0, 0,         MA, 1, 0,  0, 4, 0,         2);
        add(0, 0,         MA, 0, 0,  0, 0, 0,         2);
        add(0, 33'h10,    MA, 0, 0,  0, 0, 33'h10,    2);
        add(0, 0,         MA, 0, 0,  1, 4, 33'h10,    2);
        add(0, 33'h10,    MA, 0, 1,  1, 4, 33'h10,    0);   // 41 clr beats coalesce
        add(0, 0,         MA, 0, 0,  1, 4, 33'h10,    0);
        add(0, 33'h10,    MA, 1, 0,  0, 4, 33'h10,    0);   // 43 edge on acked bit
        add(0, 0,         MA, 1, 0,  0, 0, 33'h10,    0);   // 44 ack in GAP ignored
        add(0, 0,         MA, 0, 0,  1, 4, 33'h10,    0);
        add(0, 0,         MA, 1, 0,  0, 4, 0,         0);
        add(0, 33'h2,     MA, 0, 0,  0, 0, 33'h2,     0);   // 47 src1
        add(0, 0,         MA, 0, 0,  1, 1, 33'h2,     0);
        add(1, 0,         MA, 1, 0,  0, 0, 0,         0);   // 49 reset mid-PRESENT
        add(0, 0,         MA, 0, 0,  0, 0, 0,         0);
        add(1, 33'h40,    MA, 0, 0,  0, 0, 0,         0);   // 51 line high in reset
        add(0, 33'h40,    MA, 1, 0,  0, 0, 33'h40,    0);   // 52 edge at exit, idle ack
        add(0, 0,         MA, 0, 0,  1, 6, 33'h40,    0);
        add(0, 0,         MA, 1, 0,  0, 6, 0,         0);

        for (int k = 0; k < vecs.size(); k++) begin
            vec_t v;
            vec_t e;
            v = vecs[k];
            @(negedge clk);
            rst = v.rst; irq_in = v.irq; cfg_mask = v.msk; irq_ack = v.ack; ovf_clr = v.clr;
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            row = k;
            chk("irq_valid", 64'(irq_valid), 64'(e.vld));
            chk("pending",   64'(pending),   64'(e.pnd));
            chk("ovf_cnt",   64'(ovf_cnt),   64'(e.ovf));
            if (e.vld || e.rst) begin
                chk("irq_id", 64'(irq_id), 64'(e.id));
            end
        end

        // Narrow counter: one pend plus five coalesced edges, never acked.
        row = 100;
        @(negedge clk);
        b_rst = 1'b0;
        b_step(8'h10, 1'b0);
        chk("b_pending", 64'(b_pend), 64'h10);
        for (int j = 0; j < 5; j++) begin
            b_step(8'h00, 1'b0);
            b_step(8'h10, 1'b0);
        end
        row = 101;
        chk("b_ovf_sat", 64'(b_ovf),   64'd3);
        chk("b_valid",   64'(b_valid), 64'd1);
        chk("b_id",      64'(b_id),    64'd4);
        b_step(8'h00, 1'b0);
        b_step(8'h10, 1'b1);
        row = 102;
        chk("b_ovf_clr", 64'(b_ovf),   64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_xrbase_alfred_irq_ctrl
